// File: rtl/data_mem_ctrl_if.sv
// Request/response bundle between the LSU stage and the data-memory controller.
// The slave side is the controller; the master side is the pipeline.
interface data_mem_ctrl_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  req_valid_i;
  logic                  req_ready_o;
  logic                  req_write_i;
  logic [1:0]            mem_type_i;
  logic                  mem_sign_i;
  logic [ADDR_WIDTH-1:0] addr_i;
  logic [31:0]           write_data_i;
  logic                  resp_valid_o;
  logic                  resp_err_o;
  logic [31:0]           read_data_o;

  modport master (
    output req_valid_i, req_write_i, mem_type_i, mem_sign_i, addr_i, write_data_i,
    input  req_ready_o, resp_valid_o, resp_err_o, read_data_o
  );

  modport slave (
    input  req_valid_i, req_write_i, mem_type_i, mem_sign_i, addr_i, write_data_i,
    output req_ready_o, resp_valid_o, resp_err_o, read_data_o
  );
endinterface

// File: rtl/data_mem_ctrl.sv
// Handshaked data-memory controller: byte/half/word loads and stores on a word
// array, with optional two-beat handling of word-crossing accesses.
module data_mem_ctrl #(
  parameter int ADDR_WIDTH       = 32,
  parameter int DEPTH_WORDS      = 1024,
  parameter bit ALLOW_MISALIGNED = 1'b1
) (
  input logic             clk_i,
  input logic             rst_n_i,
  data_mem_ctrl_if.slave  bus
);

  localparam int          IDX_W   = ADDR_WIDTH - 2;
  localparam int          MEM_AW  = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [63:0] DEPTH64 = 64'(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;

  state_t state, state_next;

  logic [31:0] mem [DEPTH_WORDS];

  logic             write_q, sign_q, err_q, split_q;
  logic [1:0]       type_q, off_q;
  logic [IDX_W-1:0] idx_q;
  logic [31:0]      wdata_q;
  logic [31:0]      rd_lo, rd_hi;

  logic             accept;
  logic [1:0]       req_off;
  logic [IDX_W-1:0] req_idx;
  logic [2:0]       req_size;
  logic             req_split, req_err;

  logic [3:0]        strb_base;
  logic [7:0]        strb_wide;
  logic [63:0]       data_wide;
  logic              mem_en;
  logic [MEM_AW-1:0] mem_idx;
  logic [3:0]        mem_strb;
  logic [31:0]       mem_wdata;
  logic [31:0]       load_word, load_ext;

  // Request classification happens once, at accept, so the access states only replay it.
  always_comb begin
    req_off  = bus.addr_i[1:0];
    req_idx  = bus.addr_i[ADDR_WIDTH-1:2];
    req_size = 3'd4;
    case (bus.mem_type_i)
      2'b00:   req_size = 3'd1;
      2'b01:   req_size = 3'd2;
      default: req_size = 3'd4;
    endcase
    req_split = ({1'b0, req_off} + req_size) > 3'd4;
    req_err   = (bus.mem_type_i == 2'b11)
             || (64'(req_idx) >= DEPTH64)
             || (req_split && ((64'(req_idx) + 64'd1 >= DEPTH64) || !ALLOW_MISALIGNED));
    accept    = bus.req_valid_i && (state == IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) state <= IDLE;
    else          state <= state_next;
  end

  always_ff @(posedge clk_i) begin
    if (accept) begin
      write_q <= bus.req_write_i;
      sign_q  <= bus.mem_sign_i;
      type_q  <= bus.mem_type_i;
      off_q   <= req_off;
      idx_q   <= req_idx;
      wdata_q <= bus.write_data_i;
      split_q <= req_split;
      err_q   <= req_err;
    end
  end

  always_comb begin
    state_next       = state;
    bus.req_ready_o  = 1'b0;
    bus.resp_valid_o = 1'b0;
    bus.resp_err_o   = 1'b0;
    bus.read_data_o  = '0;
    case (state)
      IDLE: begin
        bus.req_ready_o = 1'b1;
        if (bus.req_valid_i) state_next = ACC0;
      end
      ACC0:    state_next = (split_q && !err_q) ? ACC1 : RESP;
      ACC1:    state_next = RESP;
      RESP: begin
        bus.resp_valid_o = 1'b1;
        bus.resp_err_o   = err_q;
        bus.read_data_o  = (err_q || write_q) ? 32'd0 : load_ext;
        state_next       = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Lanes pushed past byte 3 spill into the low lanes of the next word in ACC1.
  always_comb begin
    strb_base = 4'b1111;
    case (type_q)
      2'b00:   strb_base = 4'b0001;
      2'b01:   strb_base = 4'b0011;
      default: strb_base = 4'b1111;
    endcase
    strb_wide = {4'b0000, strb_base} << off_q;
    data_wide = {32'd0, wdata_q} << {off_q, 3'b000};
    mem_en    = rst_n_i && !err_q && ((state == ACC0) || (state == ACC1));
    mem_idx   = (state == ACC1) ? MEM_AW'(idx_q) + MEM_AW'(1) : MEM_AW'(idx_q);
    mem_strb  = !write_q ? 4'b0000 : ((state == ACC1) ? strb_wide[7:4] : strb_wide[3:0]);
    mem_wdata = (state == ACC1) ? data_wide[63:32] : data_wide[31:0];
  end

  always_ff @(posedge clk_i) begin
    if (mem_en) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_strb[b]) mem[mem_idx][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
      if (state == ACC0) begin
        rd_lo <= mem[mem_idx];
        rd_hi <= '0;
      end else begin
        rd_hi <= mem[mem_idx];
      end
    end
  end

  always_comb begin
    load_word = 32'({rd_hi, rd_lo} >> {off_q, 3'b000});
    load_ext  = load_word;
    case (type_q)
      2'b00:   load_ext = {{24{sign_q & load_word[7]}},  load_word[7:0]};
      2'b01:   load_ext = {{16{sign_q & load_word[15]}}, load_word[15:0]};
      default: load_ext = load_word;
    endcase
  end

endmodule
